call_stack: RTL and testbench
=============================

# call_stack

Parametrised hardware return-address stack for the single-cycle CPU datapath, replacing the fixed 8×12-bit stack. It holds `DEPTH` entries of `WIDTH` bits and supports push, pop, simultaneous push+pop (replace top) and flush. It provides a combinational top-of-stack read, an occupancy count, full/empty flags and sticky overflow/underflow flags. The overflow policy is selected at elaboration: in saturating mode a push to a full stack is dropped; in circular mode it overwrites the oldest entry.

## Interface
- `WIDTH`, 12 — entry width in bits (program-counter width); must be ≥1.
- `DEPTH`, 8 — number of entries; power of two, ≥2.
- `MODE`, `STK_SAT` — overflow policy, `stack_mode_t`: `STK_SAT` (drop the push) or `STK_WRAP` (overwrite the oldest entry).
- `clk` input 1 — the single clock; all state updates on its rising edge.
- `rst_n` input 1 — reset, synchronous and active-low.
- `push` input 1 — push `wdata`.
- `pop` input 1 — pop the top entry.
- `flush` input 1 — empty the stack and clear the error flags.
- `wdata` input `WIDTH` — data to push.
- `rdata` output `WIDTH` — current top entry; 0 when empty.
- `count` output `$clog2(DEPTH+1)` — number of valid entries, 0..`DEPTH`.
- `empty` output 1 — `count == 0`.
- `full` output 1 — `count == DEPTH`.
- `ovf` output 1 — sticky: a push occurred while full.
- `udf` output 1 — sticky: a pop occurred while empty.

## Operation
- **State registers:**
  - `mem[DEPTH]`;
  - `top`, `$clog2(DEPTH)` bits, the index of the top entry;
  - `count`;
  - `ovf` and `udf`.
- **Reset** (`rst_n`=0 at a clock edge): all `mem` entries are 0, `top` = `DEPTH-1`, `count` = 0, `ovf` = `udf` = 0.
  - Output values after reset: `rdata` = 0, `empty` = 1, `full` = 0.
- **Priority order at each edge:** reset > flush > push/pop.
- **flush:**
  - `count` ← 0, `top` ← `DEPTH-1`, `ovf` ← 0, `udf` ← 0.
  - `mem` is not cleared.
  - `push` and `pop` are ignored in the same cycle.
- **push only:**
  - Not full: `top` ← `top+1` (mod `DEPTH`), `mem[top+1]` ← `wdata`, `count` ← `count+1`.
  - Full, `STK_SAT` mode: no state change except `ovf` ← 1.
  - Full, `STK_WRAP` mode: `top` advances, the write overwrites the oldest entry, `count` stays at `DEPTH`, `ovf` ← 1.
- **pop only:**
  - Not empty: `top` ← `top-1` (mod `DEPTH`), `count` ← `count-1`.
  - Empty: no state change except `udf` ← 1.
  - Popped data is not returned on the edge; the consumer samples `rdata` before the edge.
- **push and pop together:**
  - Not empty: replace top — `mem[top]` ← `wdata`; `top` and `count` are unchanged; no error is flagged, even when full.
  - Empty: behaves as push only; `udf` is not set.
- **Index arithmetic:** `top` wraps modulo `DEPTH` by natural overflow of its `$clog2(DEPTH)` bits. `count` never exceeds `DEPTH` and never goes below 0.
- **rdata:** `count != 0 ? mem[top] : '0`.

## Timing
- All state changes take effect on the rising edge; outputs update combinationally from the new state within the same cycle.
- Read latency is 0. After a push at edge N, `rdata` equals the pushed value in cycle N+1.
- `push` and `pop` are single-cycle strobes with no handshake. An operation issued while full or empty is never stalled; it is handled by the rules in Operation.
- `ovf` and `udf`: set on the edge at which the error occurs; they stay high until `flush` or reset.
- Reset mid-operation: a reset edge discards any concurrent `push`, `pop` or `flush`.

## Structure
- Package `stack_pkg` holds:
  - typedef `stack_mode_t` (`STK_SAT`, `STK_WRAP`);
  - any shared width helper functions.
- One sub-module, `stack_ram`:
  - `DEPTH`×`WIDTH` register array with one synchronous write port and one asynchronous read port;
  - cleared on synchronous active-low reset.
- `call_stack` owns the pointer, the count, the flags and the operation decode.

## Test plan
- **Reset:** reset, then push 0x00A, 0x00B, 0x00C.
  - Required: `rdata` = 0x00C, `count` = 3.
  - Then pop ×3 → `rdata` sequence 0x00B, 0x00A, 0; `empty` = 1; `udf` = 0.
- **Saturating overflow** (`DEPTH`=8, `STK_SAT`): push 1..9.
  - Required: `count` = 8, `full` = 1, `rdata` = 8, `ovf` = 1.
  - Then pop 8× → values 7..1, then 0 with `empty` = 1.
- **Circular overflow** (`DEPTH`=8, `STK_WRAP`): push 1..10.
  - Required: `count` = 8, `rdata` = 10, `ovf` = 1.
  - Then pop 7× → values 9..3 and `count` reaching 1; the eighth pop → `empty` = 1.
- **Underflow:** pop when empty.
  - Required: `udf` = 1, `count` = 0.
  - Flush clears `udf`; push 0x123 then gives `rdata` = 0x123.
- **Replace top:** push 5, push 6, then assert push+pop with `wdata` = 7.
  - Required: `count` = 2, `rdata` = 7; pop → `rdata` = 5.
  - Push+pop when empty with `wdata` = 9 → `count` = 1, `rdata` = 9, `udf` = 0.
- **Priority:** `flush` together with `push` on a 3-deep stack → `count` = 0, `ovf` = `udf` = 0.
  - Reset asserted together with `push` → all outputs at their reset values.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and width helpers for the return-address stack.
package stack_pkg;

    typedef enum logic {
        STK_SAT  = 1'b0,
        STK_WRAP = 1'b1
    } stack_mode_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/call_stack_if.sv
// Command/status bundle of the return-address stack; master drives the commands.
interface call_stack_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
);
    import stack_pkg::*;

    localparam int unsigned CW = cnt_width(DEPTH);

    logic             push;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    modport master (
        output push, pop, flush, wdata,
        input  rdata, count, empty, full, ovf, udf
    );

    modport slave (
        input  push, pop, flush, wdata,
        output rdata, count, empty, full, ovf, udf
    );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_ram #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack: pointer, occupancy, sticky error flags and operation decode.
module call_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8,
    parameter stack_mode_t MODE  = STK_SAT
) (
    input  logic       clk,
    input  logic       rst_n,
    call_stack_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [AW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] ram_rdata;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we      = 1'b0;
        waddr   = top_q + AW'(1);

        if (bus.flush) begin
            top_d   = AW'(DEPTH - 1);
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (bus.push && bus.pop && !is_empty) begin
            // Replace top: pointer and count hold, never an error.
            we    = 1'b1;
            waddr = top_q;
        end else if (bus.push) begin
            if (!is_full || MODE == STK_WRAP) begin
                top_d = top_q + AW'(1);
                we    = 1'b1;
            end
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (bus.pop) begin
            if (is_empty) begin
                udf_d = 1'b1;
            end else begin
                top_d   = top_q - AW'(1);
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_q   <= AW'(DEPTH - 1);
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.wdata),
        .raddr (top_q),
        .rdata (ram_rdata)
    );

    assign bus.rdata = is_empty ? '0 : ram_rdata;
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule

// File: tb/tb_call_stack.sv
// Drives a saturating and a circular stack in lockstep and checks both against array models.
module tb_call_stack;
    import stack_pkg::*;

    localparam int unsigned W  = 12;
    localparam int unsigned D  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [W-1:0] wdata = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    call_stack_if #(.WIDTH(W), .DEPTH(D)) bs ();
    call_stack_if #(.WIDTH(W), .DEPTH(D)) bw ();

    assign bs.push = push;  assign bs.pop = pop;  assign bs.flush = flush;  assign bs.wdata = wdata;
    assign bw.push = push;  assign bw.pop = pop;  assign bw.flush = flush;  assign bw.wdata = wdata;

    call_stack #(.WIDTH(W), .DEPTH(D), .MODE(STK_SAT))  u_sat  (.clk(clk), .rst_n(rst_n), .bus(bs));
    call_stack #(.WIDTH(W), .DEPTH(D), .MODE(STK_WRAP)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));

    // Model: index 0 = saturating, 1 = circular; entry 0 of each stack is the oldest.
    logic [W-1:0] mq  [2][D];
    int           mn  [2];
    bit           mov [2];
    bit           mud [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input int m);
        return (mn[m] == 0) ? '0 : mq[m][mn[m]-1];
    endfunction

    task automatic model(input bit r, input bit pu, input bit po, input bit fl,
                         input logic [W-1:0] d);
        for (int m = 0; m < 2; m++) begin
            if (!r || fl) begin
                mn[m] = 0; mov[m] = 1'b0; mud[m] = 1'b0;
            end else if (pu && po && mn[m] > 0) begin
                mq[m][mn[m]-1] = d;
            end else if (pu) begin
                if (mn[m] < int'(D)) begin
                    mq[m][mn[m]] = d;
                    mn[m]++;
                end else begin
                    mov[m] = 1'b1;
                    if (m == 1) begin
                        for (int i = 0; i < int'(D) - 1; i++) mq[m][i] = mq[m][i+1];
                        mq[m][D-1] = d;
                    end
                end
            end else if (po) begin
                if (mn[m] == 0) mud[m] = 1'b1;
                else mn[m]--;
            end
        end
    endtask

    task automatic cmp_all();
        chk("sat.rdata",  bs.rdata, exp_rd(0));
        chk("sat.count",  bs.count, mn[0]);
        chk("sat.empty",  bs.empty, mn[0] == 0);
        chk("sat.full",   bs.full,  mn[0] == int'(D));
        chk("sat.ovf",    bs.ovf,   mov[0]);
        chk("sat.udf",    bs.udf,   mud[0]);
        chk("wrap.rdata", bw.rdata, exp_rd(1));
        chk("wrap.count", bw.count, mn[1]);
        chk("wrap.empty", bw.empty, mn[1] == 0);
        chk("wrap.full",  bw.full,  mn[1] == int'(D));
        chk("wrap.ovf",   bw.ovf,   mov[1]);
        chk("wrap.udf",   bw.udf,   mud[1]);
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit fl,
                        input logic [W-1:0] d);
        rst_n = r; push = pu; pop = po; flush = fl; wdata = d;
        @(posedge clk);
        model(r, pu, po, fl, d);
        #1;
        cmp_all();
        rst_n = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    initial begin
        // Reset together with a push: push must be discarded.
        step(1'b0, 1'b1, 1'b0, 1'b0, 12'h3AB);
        chk("rst.rdata", bs.rdata, 0);
        chk("rst.empty", bs.empty, 1);

        // Basic LIFO order.
        step(1, 1, 0, 0, 12'h00A);
        step(1, 1, 0, 0, 12'h00B);
        step(1, 1, 0, 0, 12'h00C);
        chk("lifo.rdata", bs.rdata, 12'h00C);
        chk("lifo.count", bs.count, 3);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, '0);
        chk("lifo.udf", bs.udf, 0);

        // Overflow: push 1..10 into both policies.
        for (int i = 1; i <= 10; i++) step(1, 1, 0, 0, W'(i));
        chk("sat.ovf_rdata",  bs.rdata, 8);
        chk("sat.ovf_flag",   bs.ovf,   1);
        chk("wrap.ovf_rdata", bw.rdata, 10);
        chk("wrap.ovf_count", bw.count, 8);
        for (int i = 0; i < 7; i++) step(1, 0, 1, 0, '0);
        chk("sat.pop7_rdata",  bs.rdata, 1);
        chk("wrap.pop7_rdata", bw.rdata, 3);
        chk("wrap.pop7_count", bw.count, 1);
        step(1, 0, 1, 0, '0);
        chk("wrap.pop8_empty", bw.empty, 1);

        // Underflow, then flush clears it.
        step(1, 0, 1, 0, '0);
        chk("udf.flag", bs.udf, 1);
        step(1, 0, 0, 1, '0);
        step(1, 1, 0, 0, 12'h123);
        chk("udf.push_rdata", bw.rdata, 12'h123);

        // Replace top, and push+pop on an empty stack.
        step(1, 0, 0, 1, '0);
        step(1, 1, 0, 0, 12'd5);
        step(1, 1, 0, 0, 12'd6);
        step(1, 1, 1, 0, 12'd7);
        chk("repl.rdata", bs.rdata, 7);
        chk("repl.count", bs.count, 2);
        step(1, 0, 1, 0, '0);
        chk("repl.pop_rdata", bs.rdata, 5);
        step(1, 0, 0, 1, '0);
        step(1, 1, 1, 0, 12'd9);
        chk("pp_empty.rdata", bs.rdata, 9);
        chk("pp_empty.udf",   bs.udf,   0);

        // Flush beats push.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, W'(i + 40));
        step(1, 1, 0, 1, 12'h777);
        chk("prio.count", bs.count, 0);

        // Random traffic biased toward filling, with rare flush and reset.
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            logic [W-1:0] d = W'($urandom);
            if (r < 2)      step(0, $urandom_range(0, 1) == 1, 0, 0, d);
            else if (r < 5) step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, d);
            else            step(1, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 0, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
